// File: rtl/mca_mem_scheduler.sv
// mca_mem_scheduler: owns the single-port spectrum RAM of the multichannel
// analyser. Sequences STOPPED/RUNNING/CLEARING from command pulses, arbitrates
// the RAM between event increments and readout, and runs the full clear.
// Optional feature macro: MCA_PRESET_TIME_EN (preset live-time run limit).
module mca_mem_scheduler #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
`ifdef MCA_PRESET_TIME_EN
  , parameter int PT_W = 32
`endif
) (
  input  logic              i_CLOCK_50,
  input  logic              i_rst,
  input  logic              i_cmd_start,
  input  logic              i_cmd_pause,
  input  logic              i_cmd_clear,
  input  logic              i_evt_valid,
  input  logic [ADDR_W-1:0] i_evt_channel,
  output logic              o_evt_ready,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_rd_ack,
  output logic [DATA_W-1:0] o_rd_data,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
`ifdef MCA_PRESET_TIME_EN
  input  logic [PT_W-1:0]   i_preset_ticks,
  output logic [PT_W-1:0]   o_live_ticks,
`endif
  output logic              o_running,
  output logic              o_clearing
);

  typedef enum logic [1:0] {STOPPED = 2'd0, RUNNING = 2'd1, CLEARING = 2'd2} run_t;
  typedef enum logic [2:0] {
    M_IDLE  = 3'd0,
    EV_RD   = 3'd1,
    EV_WAIT = 3'd2,
    EV_WR   = 3'd3,
    EV_DROP = 3'd4,
    RO_RD   = 3'd5,
    RO_WAIT = 3'd6,
    RO_ACK  = 3'd7
  } mem_t;

  run_t              r_run, w_run_nxt;
  mem_t              r_mem, w_mem_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_clr_addr;
  logic              r_last_ev;
  logic [DATA_W-1:0] r_rd_data;
  logic [DATA_W-1:0] w_sat;
  logic              w_grant_ev, w_grant_ro;
  logic              w_clr_we;
  logic              w_start_blk;
  logic              w_preset_done;

`ifdef MCA_PRESET_TIME_EN
  logic [PT_W-1:0] r_live;
  logic [PT_W-1:0] w_live_inc;

  assign w_live_inc    = r_live + PT_W'(1);
  // A run whose live time already met a nonzero preset may not be restarted.
  assign w_start_blk   = (i_preset_ticks != '0) && (r_live >= i_preset_ticks);
  assign w_preset_done = (i_preset_ticks != '0) && (w_live_inc >= i_preset_ticks);
  assign o_live_ticks  = r_live;

  // Live-time counter: counts RUNNING cycles, zeroed when a clear is accepted.
  always_ff @(posedge i_CLOCK_50) begin
    if (i_rst)
      r_live <= '0;
    else if (r_run != CLEARING && w_run_nxt == CLEARING)
      r_live <= '0;
    else if (r_run == RUNNING)
      r_live <= w_live_inc;
  end
`else
  assign w_start_blk   = 1'b0;
  assign w_preset_done = 1'b0;
`endif

  // Run FSM next state; clear writes only once the mem FSM has drained.
  always_comb begin
    w_run_nxt = r_run;
    w_clr_we  = 1'b0;
    case (r_run)
      STOPPED: begin
        if (i_cmd_clear)
          w_run_nxt = CLEARING;
        else if (!i_cmd_pause && i_cmd_start && !w_start_blk)
          w_run_nxt = RUNNING;
      end
      RUNNING: begin
        if (i_cmd_clear)
          w_run_nxt = CLEARING;
        else if (i_cmd_pause || w_preset_done)
          w_run_nxt = STOPPED;
      end
      CLEARING: begin
        if (r_mem == M_IDLE) begin
          w_clr_we = 1'b1;
          if (r_clr_addr == '1)
            w_run_nxt = STOPPED;
        end
      end
      default: w_run_nxt = STOPPED;
    endcase
  end

  // Run state and clear address; the address restarts at 0 for every clear.
  always_ff @(posedge i_CLOCK_50) begin
    if (i_rst) begin
      r_run      <= STOPPED;
      r_clr_addr <= '0;
    end else begin
      r_run <= w_run_nxt;
      if (r_run != CLEARING)
        r_clr_addr <= '0;
      else if (w_clr_we)
        r_clr_addr <= r_clr_addr + ADDR_W'(1);
    end
  end

  // Mem FSM next state with round-robin arbitration; no grants while clearing.
  always_comb begin
    w_mem_nxt  = r_mem;
    w_grant_ev = 1'b0;
    w_grant_ro = 1'b0;
    case (r_mem)
      M_IDLE: begin
        if (r_run != CLEARING) begin
          if (i_evt_valid && i_rd_req) begin
            if (r_last_ev) w_grant_ro = 1'b1;
            else           w_grant_ev = 1'b1;
          end else if (i_evt_valid) begin
            w_grant_ev = 1'b1;
          end else if (i_rd_req) begin
            w_grant_ro = 1'b1;
          end
          if (w_grant_ro)
            w_mem_nxt = RO_RD;
          else if (w_grant_ev)
            w_mem_nxt = (r_run == RUNNING) ? EV_RD : EV_DROP;
        end
      end
      EV_RD:   w_mem_nxt = EV_WAIT;
      EV_WAIT: w_mem_nxt = EV_WR;
      EV_WR:   w_mem_nxt = M_IDLE;
      EV_DROP: w_mem_nxt = M_IDLE;
      RO_RD:   w_mem_nxt = RO_WAIT;
      RO_WAIT: w_mem_nxt = RO_ACK;
      RO_ACK:  w_mem_nxt = M_IDLE;
      default: w_mem_nxt = M_IDLE;
    endcase
  end

  // Mem state, grant-time address latch, last-grant side and readout holding reg.
  // Reset marks the event side as last granted so readout wins the first tie.
  always_ff @(posedge i_CLOCK_50) begin
    if (i_rst) begin
      r_mem     <= M_IDLE;
      r_addr    <= '0;
      r_last_ev <= 1'b1;
      r_rd_data <= '0;
    end else begin
      r_mem <= w_mem_nxt;
      if (w_grant_ev) begin
        r_addr    <= i_evt_channel;
        r_last_ev <= 1'b1;
      end else if (w_grant_ro) begin
        r_addr    <= i_rd_addr;
        r_last_ev <= 1'b0;
      end
      if (r_mem == RO_ACK)
        r_rd_data <= i_mem_rdata;
    end
  end

  assign w_sat = (i_mem_rdata == '1) ? i_mem_rdata : i_mem_rdata + DATA_W'(1);

  // RAM port mux: the address is held for the whole RMW/read so the read data
  // is valid by the WR/ACK cycle regardless of where the RAM registers it.
  always_comb begin
    o_mem_addr  = '0;
    o_mem_we    = 1'b0;
    o_mem_wdata = '0;
    case (r_mem)
      M_IDLE: begin
        if (w_clr_we) begin
          o_mem_addr = r_clr_addr;
          o_mem_we   = 1'b1;
        end
      end
      EV_DROP: o_mem_addr = '0;
      EV_WR: begin
        o_mem_addr  = r_addr;
        o_mem_we    = 1'b1;
        o_mem_wdata = w_sat;
      end
      default: o_mem_addr = r_addr;
    endcase
  end

  assign o_evt_ready = (r_mem == EV_RD) || (r_mem == EV_DROP);
  assign o_rd_ack    = (r_mem == RO_ACK);
  assign o_rd_data   = (r_mem == RO_ACK) ? i_mem_rdata : r_rd_data;
  assign o_running   = (r_run == RUNNING);
  assign o_clearing  = (r_run == CLEARING);

endmodule
